// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-file sizing and well-known register indices
package reg_scoreboard_pkg;
  localparam int NREGS = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W = 2;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA = 5'd31;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: issue, writeback and status signals between decode and the scoreboard
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;
  logic issue_valid, use_rs, use_rt, issue_wr_en, issue_ready;
  logic wb_valid, flush, busy, err_underflow;
  reg_idx_t issue_rs, issue_rt, issue_dst, wb_dst;
  logic [NREGS-1:0] pending_mask;
  modport master(
    output issue_valid, issue_rs, issue_rt, use_rs, use_rt, issue_wr_en, issue_dst,
    output wb_valid, wb_dst, flush,
    input issue_ready, pending_mask, busy, err_underflow
  );
  modport slave(
    input issue_valid, issue_rs, issue_rt, use_rs, use_rt, issue_wr_en, issue_dst,
    input wb_valid, wb_dst, flush,
    output issue_ready, pending_mask, busy, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating in-flight write counter for one architectural register
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         nonzero_o,
  output logic         at_max_o
);
  logic [W-1:0] count_q, count_d;
  assign count_o = count_q;
  assign nonzero_o = |count_q;
  assign at_max_o = &count_q;
  always_comb
    count_d = clr_i ? '0
            : (inc_i && !dec_i && !at_max_o) ? count_q + 1'b1
            : (dec_i && !inc_i && nonzero_o) ? count_q - 1'b1
            : count_q;
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes and stalls issue on RAW or counter-full hazards
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input logic clk,
  input logic rst,
  reg_scoreboard_if.slave sb
);
  logic [CNT_W-1:0] cnt [1:NREGS-1];
  logic [NREGS-1:0] nz, mx, one, inc, dec, eff_nz, eff_mx;
  logic accept, src_block, full_block, err_q, err_d;
  assign {nz[0], mx[0], one[0], inc[0], dec[0]} = '0;
  for (genvar i = 1; i < NREGS; i++) begin : g_cnt
    assign inc[i] = accept && sb.issue_wr_en && sb.issue_dst == reg_idx_t'(i);
    assign dec[i] = sb.wb_valid && sb.wb_dst == reg_idx_t'(i) && nz[i];
    assign one[i] = cnt[i] == CNT_W'(1);
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .inc_i(inc[i]), .dec_i(dec[i]), .clr_i(sb.flush),
      .count_o(cnt[i]), .nonzero_o(nz[i]), .at_max_o(mx[i])
    );
  end
  // Same-cycle writeback releases its register before the hazard check sees it.
  assign eff_nz = nz & ~(dec & one);
  assign eff_mx = mx & ~dec;
  always_comb begin
    src_block = (sb.use_rs && eff_nz[sb.issue_rs]) || (sb.use_rt && eff_nz[sb.issue_rt]);
    full_block = sb.issue_wr_en && eff_mx[sb.issue_dst];
    sb.issue_ready = !src_block && !full_block && !sb.flush;
    accept = sb.issue_valid && sb.issue_ready;
    err_d = err_q || (sb.wb_valid && sb.wb_dst != REG_ZERO && !nz[sb.wb_dst]);
  end
  always_ff @(posedge clk)
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  assign sb.pending_mask = nz;
  assign sb.busy = |nz;
  assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and randomized checks against a per-register count model
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;
  localparam int MAXC = 3;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  reg_scoreboard_if sbif();
  reg_scoreboard dut(.clk(clk), .rst(rst), .sb(sbif));
  int cnt [NREGS];
  bit err_m;
  int nchk = 0, nerr = 0;
  bit rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int eff(input int i, input bit wbv, input int wbd);
    return cnt[i] - ((wbv && wbd == i && cnt[i] != 0) ? 1 : 0);
  endfunction

  function automatic logic [31:0] mmask();
    logic [31:0] m = '0;
    for (int i = 1; i < NREGS; i++) m[i] = cnt[i] != 0;
    return m;
  endfunction

  task automatic cyc(input bit v, input bit we, input int dst, input bit urs, input int rs,
                     input bit urt, input int rt, input bit wbv, input int wbd,
                     input bit fl, input bit r, output bit ready);
    bit exp_rdy;
    rst = r;
    sbif.issue_valid = v; sbif.issue_wr_en = we; sbif.issue_dst = ADDR_W'(dst);
    sbif.use_rs = urs; sbif.issue_rs = ADDR_W'(rs);
    sbif.use_rt = urt; sbif.issue_rt = ADDR_W'(rt);
    sbif.wb_valid = wbv; sbif.wb_dst = ADDR_W'(wbd); sbif.flush = fl;
    #1;
    exp_rdy = !((urs && rs != 0 && eff(rs, wbv, wbd) != 0) ||
                (urt && rt != 0 && eff(rt, wbv, wbd) != 0) ||
                (we && dst != 0 && eff(dst, wbv, wbd) == MAXC) || fl);
    ready = sbif.issue_ready;
    chk("issue_ready", 32'(ready), 32'(exp_rdy));
    chk("pending_mask", sbif.pending_mask, mmask());
    chk("busy", 32'(sbif.busy), 32'(mmask() != 0));
    chk("err_underflow", 32'(sbif.err_underflow), 32'(err_m));
    @(posedge clk);
    if (r) begin
      foreach (cnt[i]) cnt[i] = 0;
      err_m = 0;
    end else begin
      if (wbv && wbd != 0 && cnt[wbd] == 0) err_m = 1;
      if (fl) foreach (cnt[i]) cnt[i] = 0;
      else
        for (int i = 1; i < NREGS; i++)
          cnt[i] += ((v && exp_rdy && we && dst == i) ? 1 : 0) - ((wbv && wbd == i && cnt[i] != 0) ? 1 : 0);
    end
    @(negedge clk);
  endtask

  function automatic int pick();
    return ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
  endfunction

  initial begin
    foreach (cnt[i]) cnt[i] = 0;
    err_m = 0;
    sbif.issue_valid = 0; sbif.issue_wr_en = 0; sbif.issue_dst = 0;
    sbif.use_rs = 0; sbif.issue_rs = 0; sbif.use_rt = 0; sbif.issue_rt = 0;
    sbif.wb_valid = 0; sbif.wb_dst = 0; sbif.flush = 0;
    @(posedge clk);
    @(negedge clk);
    cyc(0,0,0, 0,0, 0,0, 0,0, 0,1, rdy);
    chk("rst_mask", sbif.pending_mask, 32'h0);
    chk("rst_busy", 32'(sbif.busy), 32'h0);
    chk("rst_err", 32'(sbif.err_underflow), 32'h0);
    cyc(1,1,8, 0,0, 0,0, 0,0, 0,0, rdy);
    chk("t1_ready", 32'(rdy), 32'h1);
    chk("t1_mask", sbif.pending_mask, 32'h0000_0100);
    chk("t1_busy", 32'(sbif.busy), 32'h1);
    cyc(1,0,0, 1,8, 0,0, 0,0, 0,0, rdy);
    chk("t2_stall", 32'(rdy), 32'h0);
    cyc(1,0,0, 1,8, 0,0, 1,8, 0,0, rdy);
    chk("t2_bypass", 32'(rdy), 32'h1);
    chk("t2_mask", sbif.pending_mask, 32'h0);
    for (int k = 0; k < 3; k++) cyc(1,1,9, 0,0, 0,0, 0,0, 0,0, rdy);
    cyc(1,1,9, 0,0, 0,0, 0,0, 0,0, rdy);
    chk("t3_full", 32'(rdy), 32'h0);
    cyc(1,1,9, 0,0, 0,0, 1,9, 0,0, rdy);
    chk("t3_full_wb", 32'(rdy), 32'h1);
    chk("t3_mask", sbif.pending_mask, 32'h0000_0200);
    cyc(1,1,9, 0,0, 0,0, 0,0, 0,0, rdy);
    chk("t3_still_full", 32'(rdy), 32'h0);
    for (int k = 0; k < 3; k++) cyc(0,0,0, 0,0, 0,0, 1,9, 0,0, rdy);
    chk("t3_drained", sbif.pending_mask, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc(1,1,0, 1,0, 1,0, 0,0, 0,0, rdy);
      chk("t4_r0_ready", 32'(rdy), 32'h1);
    end
    cyc(0,0,0, 0,0, 0,0, 1,0, 0,0, rdy);
    chk("t4_mask", sbif.pending_mask, 32'h0);
    chk("t4_err", 32'(sbif.err_underflow), 32'h0);
    cyc(1,1,5, 0,0, 0,0, 0,0, 0,0, rdy);
    cyc(1,1,31, 0,0, 0,0, 0,0, 0,0, rdy);
    cyc(1,1,12, 0,0, 0,0, 0,0, 0,0, rdy);
    chk("t5_mask", sbif.pending_mask, 32'h8000_1020);
    cyc(1,1,7, 0,0, 0,0, 0,0, 1,0, rdy);
    chk("t5_flush_ready", 32'(rdy), 32'h0);
    chk("t5_flush_mask", sbif.pending_mask, 32'h0);
    chk("t5_flush_busy", 32'(sbif.busy), 32'h0);
    cyc(0,0,0, 0,0, 0,0, 1,3, 0,0, rdy);
    chk("t6_err", 32'(sbif.err_underflow), 32'h1);
    cyc(0,0,0, 0,0, 0,0, 0,0, 1,0, rdy);
    chk("t6_err_flush", 32'(sbif.err_underflow), 32'h1);
    cyc(0,0,0, 0,0, 0,0, 0,0, 0,1, rdy);
    chk("t6_err_rst", 32'(sbif.err_underflow), 32'h0);
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, pick(),
          $urandom_range(0, 1) == 1, pick(), $urandom_range(0, 1) == 1, pick(),
          $urandom_range(0, 9) < 4, pick(), $urandom_range(0, 39) == 0,
          $urandom_range(0, 149) == 0, rdy);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
